// File: rtl/divider.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | divider : 32-bit signed/unsigned divide and remainder, radix-2 restoring.   |
// | Divide-by-zero and signed overflow finish in one cycle.                     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+

package divider_pkg;
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;
endpackage

module divider
    import divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  div_op_e     op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        ready,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state;
    state_e      next_state;

    logic [5:0]  count;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;
    logic        is_rem;

    logic        start;
    logic        in_signed;
    logic        in_rem;
    logic        div_zero;
    logic        overflow;
    logic        bypass;
    logic [31:0] bypass_res;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] step_q;
    logic [31:0] step_r;
    logic [31:0] final_res;

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == CALC);
    assign valid = (state == DONE);

    always_comb begin
        start      = ready && en && !flush;
        in_signed  = (op == DIV) || (op == REM);
        in_rem     = (op == REM) || (op == REMU);
        div_zero   = (op_b == 32'h0000_0000);
        overflow   = in_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        bypass     = div_zero || overflow;
        abs_a      = (in_signed && op_a[31]) ? -op_a : op_a;
        abs_b      = (in_signed && op_b[31]) ? -op_b : op_b;
        if (div_zero)
            bypass_res = in_rem ? op_a : 32'hFFFF_FFFF;
        else
            bypass_res = in_rem ? 32'h0000_0000 : 32'h8000_0000;
    end

    // One restoring step; the final step feeds the sign fix-up directly so the
    // corrected result is registered on the same edge that enters DONE.
    always_comb begin
        shifted   = {rem, quot[31]};
        diff      = shifted - {1'b0, divisor};
        step_q    = {quot[30:0], ~diff[32]};
        step_r    = diff[32] ? shifted[31:0] : diff[31:0];
        if (is_rem)
            final_res = neg_r ? -step_r : step_r;
        else
            final_res = neg_q ? -step_q : step_q;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = bypass ? DONE : CALC;
            CALC: if (count == 6'd0) next_state = DONE;
            DONE: begin
                if (start) next_state = bypass ? DONE : CALC;
                else       next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 6'd0;
            quot    <= 32'h0000_0000;
            rem     <= 32'h0000_0000;
            divisor <= 32'h0000_0000;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_rem  <= 1'b0;
            result  <= 32'h0000_0000;
        end else if (start) begin
            count   <= 6'd31;
            quot    <= abs_a;
            rem     <= 32'h0000_0000;
            divisor <= abs_b;
            neg_q   <= in_signed && (op_a[31] ^ op_b[31]);
            neg_r   <= in_signed && op_a[31];
            is_rem  <= in_rem;
            if (bypass) result <= bypass_res;
        end else if (state == CALC && !flush) begin
            quot <= step_q;
            rem  <= step_r;
            if (count == 6'd0) result <= final_res;
            else               count  <= count - 6'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 No parameters; operand and result width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  start request; sampled only while ready=1.
REQ-005 op  input  div_op_e  operation select: DIV, DIVU, REM, REMU; sampled with en.
REQ-006 op_a  input  32  dividend; sampled with en.
REQ-007 op_b  input  32  divisor; sampled with en.
REQ-008 flush  input  1  abort; kills any in-flight operation.
REQ-009 ready  output  1  high when a start is accepted this cycle (state IDLE or DONE).
REQ-010 busy  output  1  high while state is CALC.
REQ-011 valid  output  1  one-cycle pulse; result is final.
REQ-012 result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-013 States: IDLE, CALC, DONE; DONE lasts exactly one cycle and then goes to IDLE unless a new start is accepted.
REQ-014 Start is accepted at edge T when ready=1, en=1 and flush=0; op, op_a and op_b are latched internally, so inputs may change after T.
REQ-015 en is ignored while busy=1; no queuing of requests.
REQ-016 Normal operation is radix-2 restoring, one quotient bit per cycle, with a 6-bit iteration counter running 31 down to 0.
REQ-017 Normal latency: CALC for cycles T+1 to T+32, DONE and valid=1 at T+33.
REQ-018 Signed ops (DIV, REM) divide the absolute values of the operands.
REQ-019 Signed quotient is negated when the operand signs differ.
REQ-020 Signed remainder takes the sign of the dividend.
REQ-021 Sign correction is applied on entry to DONE, and result is registered.
REQ-022 Divide by zero (op_b=0) bypasses CALC and goes to DONE at T+1.
REQ-023 Divide-by-zero results: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
REQ-024 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) bypasses CALC and goes to DONE at T+1.
REQ-025 Signed-overflow results: DIV gives 0x80000000; REM gives 0.
REQ-026 Dividend of 0 with a nonzero divisor takes the normal 33-cycle path and returns 0.
REQ-027 result holds its last value outside DONE and updates only on the DONE entry edge.
REQ-028 A start accepted in DONE (back-to-back) moves the block to CALC, or to DONE for the bypass cases; valid is still the single pulse of the finishing operation.
REQ-029 flush in any state forces IDLE on the next edge, suppresses valid and leaves result unchanged.
REQ-030 flush has priority over en in the same cycle, so no start is accepted.
REQ-031 The iteration counter does not wrap: the exit from CALC is taken when count=0.

Reset
REQ-032 rst=1 at an edge forces state to IDLE, regardless of the current state.
REQ-033 Reset output values: ready=1, busy=0, valid=0, result=0x00000000; the counter and operand registers clear to 0.
REQ-034 rst has priority over flush and en.
REQ-035 Reset in the middle of CALC discards the operation, and no valid is produced.

Verification
REQ-036 DIVU 100/7 at T -> busy=1 for T+1..T+32; valid=1 and result=14 at T+33; REMU 100/7 -> 2.
REQ-037 DIV 0xFFFFFFF9/2 (-7/2) -> result=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-038 DIVU 5/0 -> valid at T+1 with result=0xFFFFFFFF; REMU 5/0 -> result=5; busy stays 0.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> valid at T+1 with result=0x80000000; REM -> result=0.
REQ-040 Flush and back-to-back: start DIVU 100/7, flush at T+10 -> no valid pulse, ready=1 at T+11, result keeps its prior value; then start at DONE with DIVU 9/3 -> valid=1 and result=3 exactly 33 cycles later.
REQ-041 Reset mid-operation: rst at T+5 of an operation -> ready=1, busy=0 and valid=0 on the next cycle; a later start is serviced normally.
